pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and offset width in bits.
REQ-002 SHALL have parameter INC, default 1, sequential increment step.
REQ-003 SHALL have parameter HIST_DEPTH, default 2, age in enabled cycles of the PC used as relative base; legal range 1..8.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 2..16.
REQ-005 SHALL have parameter RST_VEC, default 0, PC value after reset.
REQ-006 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port enable  in  1  1 = advance, 0 = hold all state.
REQ-009 SHALL have port trap  in  1  redirect to trap_vec.
REQ-010 SHALL have port trap_vec  in  ADDR_W  absolute trap target.
REQ-011 SHALL have port br_take  in  1  take relative branch.
REQ-012 SHALL have port br_off  in  ADDR_W  two's-complement branch offset.
REQ-013 SHALL have port jmp_take  in  1  take relative jump.
REQ-014 SHALL have port jmp_off  in  ADDR_W  two's-complement jump offset.
REQ-015 SHALL have port call  in  1  qualifies jmp_take as a call (push return address).
REQ-016 SHALL have port ret  in  1  return to RAS top.
REQ-017 SHALL have port pc  out  ADDR_W  current program counter, registered.
REQ-018 SHALL have port ras_empty  out  1  RAS holds 0 entries.
REQ-019 SHALL have port ras_full  out  1  RAS holds RAS_DEPTH entries.
REQ-020 SHALL have port ras_err  out  1  sticky: ret on empty RAS or call on full RAS.

Function
REQ-021 SHALL keep history hist[0..HIST_DEPTH-1]; on each enabled edge hist[0] <= pc and hist[i] <= hist[i-1].
REQ-022 SHALL define base = hist[HIST_DEPTH-1], i.e. the PC HIST_DEPTH enabled cycles earlier.
REQ-023 SHALL select next PC with fixed priority: trap -> trap_vec; br_take -> base+br_off; jmp_take -> base+jmp_off; ret -> RAS top; else pc+INC.
REQ-024 SHALL compute all sums modulo 2^ADDR_W, with no overflow flag.
REQ-025 SHALL register the selected next PC on the enabled edge; the redirect is visible on pc one cycle after the request.
REQ-026 SHALL push base+INC when jmp_take&call is the winning selection; call without jmp_take SHALL be ignored.
REQ-027 SHALL pop and use the RAS top when ret is the winning selection with the RAS non-empty.
REQ-028 SHALL, on a winning ret with the RAS empty, take pc+INC, leave the RAS unchanged and set ras_err.
REQ-029 SHALL, on a push with the RAS full, discard the oldest entry, store the new entry on top, keep the count at RAS_DEPTH and set ras_err.
REQ-030 SHALL ignore a losing ret or call, with no push, no pop and no error.
REQ-031 SHALL, with enable=0, hold pc, hist, RAS and flags, and ignore all request inputs including trap.
REQ-032 SHALL drive ras_empty and ras_full from registered count state, valid in the cycle after each push or pop.

Reset
REQ-033 SHALL, while rst=1 at an edge, set pc=RST_VEC, every hist entry=RST_VEC, RAS count=0, ras_err=0; rst SHALL override enable.
REQ-034 SHALL, after reset, show ras_empty=1 and ras_full=0; RAS entry contents are don't-care.
REQ-035 SHALL, on reset asserted mid-operation, discard any in-flight redirect; the first post-reset edge with enable=1 and no request gives pc=RST_VEC+INC.

Structure
REQ-036 SHALL place the next-PC select encoding (SEL_SEQ, SEL_TRAP, SEL_BR, SEL_JMP, SEL_RET) in shared package pc_pkg.
REQ-037 SHALL implement the return stack as sub-module pc_ras (params ADDR_W, RAS_DEPTH; push, pop, data, top, count, empty, full).
REQ-038 SHALL assert legal ranges for HIST_DEPTH and RAS_DEPTH at elaboration.

Verification
REQ-039 SHALL cover: reset, then 5 enabled idle cycles -> pc = 0,1,2,3,4,5.
REQ-040 SHALL cover (HIST_DEPTH=2): br_take with br_off=0x10 while pc=5 -> next pc = 3+0x10 = 0x13.
REQ-041 SHALL cover: trap with trap_vec=0x80 plus br_take and jmp_take in the same cycle -> next pc=0x80, RAS unchanged.
REQ-042 SHALL cover: jmp_take&call with jmp_off=0x40 at pc=8 -> pc=0x46, RAS top=7; later ret -> pc=7, ras_empty=1.
REQ-043 SHALL cover (RAS_DEPTH=4): five calls -> ras_full=1, ras_err=1, then four rets return the last four addresses in LIFO order; a fifth ret -> pc+INC.
REQ-044 SHALL cover: enable=0 for 3 cycles with br_take=1 -> pc and hist frozen, no redirect; rst asserted mid-stream -> pc=RST_VEC next cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC source select.
package pc_pkg;

   // Source of the next program counter, listed in descending priority
   // after the default sequential step.
   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_TRAP = 3'd1,
      SEL_BR   = 3'd2,
      SEL_JMP  = 3'd3,
      SEL_RET  = 3'd4
   } selT;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack. Entry 0 is always the top; a push shifts every entry
// one place deeper so that, when full, the oldest entry falls off the bottom.
module pc_ras #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4,
   localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] data,
   output logic [ADDR_W-1:0] top,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   logic [ADDR_W-1:0] stack [RAS_DEPTH];

   // Occupancy count; saturates at RAS_DEPTH because an overflowing push replaces the oldest entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   // Entry storage shifts toward the bottom on push and toward the top on pop; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[0] <= data;
         for (int i = 1; i < RAS_DEPTH; i++) begin
            stack[i] <= stack[i-1];
         end
      end else if (pop) begin
         for (int i = 0; i < RAS_DEPTH - 1; i++) begin
            stack[i] <= stack[i+1];
         end
      end
   end

   assign top   = stack[0];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(RAS_DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential step, trap, PC-relative branch/jump
// against a delayed base PC, call/return through a small return-address stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                INC        = 1,
   parameter int                HIST_DEPTH = 2,
   parameter int                RAS_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RST_VEC    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              trap,
   input  logic [ADDR_W-1:0] trap_vec,
   input  logic              br_take,
   input  logic [ADDR_W-1:0] br_off,
   input  logic              jmp_take,
   input  logic [ADDR_W-1:0] jmp_off,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   if (HIST_DEPTH < 1 || HIST_DEPTH > 8) begin : gBadHistDepth
      $error("pc_sequencer: HIST_DEPTH must be in 1..8");
   end
   if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : gBadRasDepth
      $error("pc_sequencer: RAS_DEPTH must be in 2..16");
   end

   logic [ADDR_W-1:0] hist [HIST_DEPTH];
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] nextPc;
   logic [ADDR_W-1:0] rasTop;
   logic [CNT_W-1:0]  rasCount;
   logic              rasEmpty;
   logic              rasFull;
   logic              rasPush;
   logic              rasPop;
   logic              errSet;
   selT               sel;

   // The relative base is the PC from HIST_DEPTH enabled cycles ago.
   assign base = hist[HIST_DEPTH-1];

   // Fixed-priority next-PC selection; a ret on an empty stack falls back to the sequential step.
   always_comb begin
      sel    = SEL_SEQ;
      nextPc = pc + ADDR_W'(INC);
      if (trap) begin
         sel    = SEL_TRAP;
         nextPc = trap_vec;
      end else if (br_take) begin
         sel    = SEL_BR;
         nextPc = base + br_off;
      end else if (jmp_take) begin
         sel    = SEL_JMP;
         nextPc = base + jmp_off;
      end else if (ret) begin
         sel    = SEL_RET;
         nextPc = rasEmpty ? (pc + ADDR_W'(INC)) : rasTop;
      end
   end

   // Stack traffic only for the winning selection on an enabled, non-reset edge.
   assign rasPush = enable && !rst && (sel == SEL_JMP) && call;
   assign rasPop  = enable && !rst && (sel == SEL_RET) && !rasEmpty;
   assign errSet  = enable && (((sel == SEL_RET) && rasEmpty) || (rasPush && rasFull));

   pc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) uRas (
      .clk   (clk),
      .rst   (rst),
      .push  (rasPush),
      .pop   (rasPop),
      .data  (base + ADDR_W'(INC)),
      .top   (rasTop),
      .count (rasCount),
      .empty (rasEmpty),
      .full  (rasFull)
   );

   // PC and history advance together on enabled edges; reset overrides enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RST_VEC;
         for (int i = 0; i < HIST_DEPTH; i++) begin
            hist[i] <= RST_VEC;
         end
      end else if (enable) begin
         pc      <= nextPc;
         hist[0] <= pc;
         for (int i = 1; i < HIST_DEPTH; i++) begin
            hist[i] <= hist[i-1];
         end
      end
   end

   // Sticky stack-misuse flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ras_err <= 1'b0;
      end else if (errSet) begin
         ras_err <= 1'b1;
      end
   end

   assign ras_empty = (rasCount == '0);
   assign ras_full  = rasFull;

endmodule
